// File: rtl/bounding_box_if.sv
// Start/done handshake, image read port and box result
// shared between the bounding-box scanner and its owner.
interface bounding_box_if;
  logic        start;
  logic        done;
  logic        found;
  logic [31:0] readAddr;
  logic [15:0] readdata;
  logic [10:0] xMin;
  logic [10:0] xMax;
  logic [10:0] yMin;
  logic [10:0] yMax;

  modport master (
    output start, readdata,
    input  done, found, readAddr,
    input  xMin, xMax, yMin, yMax
  );

  modport slave (
    input  start, readdata,
    output done, found, readAddr,
    output xMin, xMax, yMin, yMax
  );
endinterface

// File: rtl/bounding_box.sv
// Scans a row-major byte image for dark pixels and reports their box.
// Optional padding of the box is enabled by defining BBOX_MARGIN_EN.
module bounding_box #(
  parameter int WIDTH     = 100,
  parameter int HEIGHT    = 100,
  parameter int BPP       = 3,
  parameter int BASE_ADDR = 0,
  parameter int THRESHOLD = 128,
  parameter int READ_LAT  = 2,
  parameter int MARGIN    = 2
) (
  input logic           clk,
  input logic           rst_n,
  bounding_box_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE, FETCH, SAMPLE, FINAL
  } state_e;

  localparam logic [10:0] X_LAST   = 11'(WIDTH - 1);
  localparam logic [10:0] Y_LAST   = 11'(HEIGHT - 1);
  localparam logic [15:0] LAT_LAST = 16'(READ_LAT - 1);
  localparam logic [7:0]  CH_LAST  = 8'(BPP - 1);
  localparam logic [8:0]  THR      = 9'(THRESHOLD);
`ifdef BBOX_MARGIN_EN
  localparam logic [10:0] MARG     = 11'(MARGIN);
`else
  localparam int unused_margin     = MARGIN;
`endif

  state_e      state_q, state_d;
  logic [15:0] lat_q, lat_d;
  logic [7:0]  ch_q, ch_d;
  logic [10:0] x_q, x_d, y_q, y_d;
  logic [10:0] minx_q, minx_d, miny_q, miny_d;
  logic [10:0] maxx_q, maxx_d, maxy_q, maxy_d;
  logic        hit_q, hit_d, dark_q, dark_d;
  logic [31:0] addr_q, addr_d;
  logic        done_q, done_d, found_q, found_d;
  logic [10:0] xmin_q, xmin_d, xmax_q, xmax_d;
  logic [10:0] ymin_q, ymin_d, ymax_q, ymax_d;
  logic        px_dark;
  logic        unused_hi;

  assign unused_hi = ^bus.readdata[15:8];
  assign px_dark   = dark_q &
                     ({1'b0, bus.readdata[7:0]} < THR);

  always_comb begin
    state_d = state_q;
    lat_d   = lat_q;
    ch_d    = ch_q;
    x_d     = x_q;
    y_d     = y_q;
    minx_d  = minx_q;
    miny_d  = miny_q;
    maxx_d  = maxx_q;
    maxy_d  = maxy_q;
    hit_d   = hit_q;
    dark_d  = dark_q;
    addr_d  = addr_q;
    done_d  = 1'b0;
    found_d = found_q;
    xmin_d  = xmin_q;
    xmax_d  = xmax_q;
    ymin_d  = ymin_q;
    ymax_d  = ymax_q;
    unique case (state_q)
      IDLE: if (bus.start) begin
        x_d     = '0;
        y_d     = '0;
        ch_d    = '0;
        lat_d   = '0;
        addr_d  = 32'(BASE_ADDR);
        minx_d  = X_LAST;
        miny_d  = Y_LAST;
        maxx_d  = '0;
        maxy_d  = '0;
        hit_d   = 1'b0;
        dark_d  = 1'b1;
        state_d = FETCH;
      end
      FETCH: begin
        if (lat_q == LAT_LAST) begin
          lat_d   = '0;
          state_d = SAMPLE;
        end else begin
          lat_d = lat_q + 16'd1;
        end
      end
      SAMPLE: begin
        addr_d  = addr_q + 32'd1;
        state_d = FETCH;
        if (ch_q != CH_LAST) begin
          ch_d   = ch_q + 8'd1;
          dark_d = px_dark;
        end else begin
          ch_d   = '0;
          dark_d = 1'b1;
          if (px_dark) begin
            hit_d = 1'b1;
            if (x_q < minx_q) minx_d = x_q;
            if (y_q < miny_q) miny_d = y_q;
            if (x_q > maxx_q) maxx_d = x_q;
            if (y_q > maxy_q) maxy_d = y_q;
          end
          if (x_q == X_LAST) begin
            x_d = '0;
            y_d = y_q + 11'd1;
            if (y_q == Y_LAST) state_d = FINAL;
          end else begin
            x_d = x_q + 11'd1;
          end
        end
      end
      FINAL: begin
        done_d  = 1'b1;
        found_d = hit_q;
        state_d = IDLE;
        if (hit_q) begin
`ifdef BBOX_MARGIN_EN
          // Clamp the padded box to the frame without wrapping
          xmin_d = (minx_q >= MARG) ? minx_q - MARG : '0;
          ymin_d = (miny_q >= MARG) ? miny_q - MARG : '0;
          xmax_d = (({1'b0, maxx_q} + {1'b0, MARG}) > {1'b0, X_LAST})
                   ? X_LAST : maxx_q + MARG;
          ymax_d = (({1'b0, maxy_q} + {1'b0, MARG}) > {1'b0, Y_LAST})
                   ? Y_LAST : maxy_q + MARG;
`else
          xmin_d = minx_q;
          ymin_d = miny_q;
          xmax_d = maxx_q;
          ymax_d = maxy_q;
`endif
        end else begin
          xmin_d = '0;
          ymin_d = '0;
          xmax_d = X_LAST;
          ymax_d = Y_LAST;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      lat_q   <= '0;
      ch_q    <= '0;
      x_q     <= '0;
      y_q     <= '0;
      minx_q  <= '0;
      miny_q  <= '0;
      maxx_q  <= '0;
      maxy_q  <= '0;
      hit_q   <= 1'b0;
      dark_q  <= 1'b1;
      addr_q  <= '0;
      done_q  <= 1'b0;
      found_q <= 1'b0;
      xmin_q  <= '0;
      xmax_q  <= '0;
      ymin_q  <= '0;
      ymax_q  <= '0;
    end else begin
      state_q <= state_d;
      lat_q   <= lat_d;
      ch_q    <= ch_d;
      x_q     <= x_d;
      y_q     <= y_d;
      minx_q  <= minx_d;
      miny_q  <= miny_d;
      maxx_q  <= maxx_d;
      maxy_q  <= maxy_d;
      hit_q   <= hit_d;
      dark_q  <= dark_d;
      addr_q  <= addr_d;
      done_q  <= done_d;
      found_q <= found_d;
      xmin_q  <= xmin_d;
      xmax_q  <= xmax_d;
      ymin_q  <= ymin_d;
      ymax_q  <= ymax_d;
    end
  end

  assign bus.done     = done_q;
  assign bus.found    = found_q;
  assign bus.readAddr = addr_q;
  assign bus.xMin     = xmin_q;
  assign bus.xMax     = xmax_q;
  assign bus.yMin     = ymin_q;
  assign bus.yMax     = ymax_q;

endmodule

// File: doc/bounding_box.md
# bounding_box

- Scans a packed, row-major image in byte memory and computes the tight bounding box of foreground pixels.
- A pixel is foreground when all of its channel bytes are below a threshold, i.e. a dark object on a light background.
- Sits directly upstream of the header and cropping stages. It produces the `xMin`/`xMax`/`yMin`/`yMax` values those stages consume.
- The owning top level sequences this block, then header, then cropping.

## Interface
Parameters:
- `WIDTH`, 100: image width in pixels.
- `HEIGHT`, 100: image height in pixels.
- `BPP`, 3: bytes per pixel, at least 1.
- `BASE_ADDR`, 0: byte address of pixel (0,0).
- `THRESHOLD`, 128: a channel byte counts as dark when it is `< THRESHOLD` (unsigned 8-bit).
- `READ_LAT`, 2: cycles from a `readAddr` change to valid `readdata`; at least 1.
- `MARGIN`, 2: padding in pixels. Used only under `BBOX_MARGIN_EN`.

Ports:
- `clk` in 1: sole clock.
- `rst_n` in 1: asynchronous, active-low reset.
- `start` in 1: begin a scan. Sampled only in IDLE.
- `done` out 1: one-cycle pulse when the result is committed.
- `found` out 1: the last scan contained at least one foreground pixel.
- `readAddr` out 32: byte address into image memory.
- `readdata` in 16: memory data. Only `[7:0]` is used.
- `xMin`, `xMax`, `yMin`, `yMax` out 11 each: bounding box, inclusive pixel coordinates.

## Operation
- Reset values: `done`=0, `found`=0, `readAddr`=0, `xMin`=0, `yMin`=0, `xMax`=0, `yMax`=0, state IDLE.
- **IDLE**
  - On `start`=1: x=y=ch=0; `readAddr`=`BASE_ADDR`; running min set to (WIDTH-1, HEIGHT-1); running max set to (0,0); hit=0; pixel-dark=1; go to FETCH.
  - `start`=0: stay in IDLE.
- **FETCH**
  - Hold `readAddr` for exactly `READ_LAT` cycles, then go to SAMPLE.
- **SAMPLE** (one cycle)
  - pixel-dark &= (`readdata[7:0]` < `THRESHOLD`).
  - Increment `readAddr` by 1.
  - If ch < BPP-1: ch++ and return to FETCH.
  - Otherwise the pixel is complete:
    - If pixel-dark: update running min/max with (x,y) and set hit=1.
    - Reset ch=0 and pixel-dark=1.
    - Advance x; at x=WIDTH-1, wrap x to 0 and increment y.
    - If the pixel was (WIDTH-1, HEIGHT-1), go to FINAL; else go to FETCH.
- **FINAL** (one cycle)
  - Register outputs: `found`=hit.
  - If hit: box = running min/max (with margin if enabled).
  - If no hit: box = full frame, i.e. (0, 0, WIDTH-1, HEIGHT-1), so downstream crops the whole image.
  - Pulse `done`=1 for one cycle; go to IDLE.
- Outputs hold their committed values until the next FINAL or reset.
- `start` outside IDLE is ignored, including `start` held high through a scan.
- Reset mid-scan: immediately return to reset values; no `done` is issued.
- Address arithmetic is incremental: `readAddr` = `BASE_ADDR` + (y·WIDTH + x)·BPP + ch. There is no row padding and no multiplier is needed.
- Coordinate counters and running min/max are 11-bit unsigned. Widths must accommodate WIDTH and HEIGHT up to 2047.

## Timing
- Let E0 be the clock edge where `start` is accepted.
- Each byte takes `READ_LAT`+1 cycles.
- Total bytes N = WIDTH·HEIGHT·BPP.
- The final SAMPLE occurs at edge E0 + N·(READ_LAT+1).
- `done` and the outputs go high at edge E0 + N·(READ_LAT+1) + 1. `done` falls on the next edge.
- A new `start` is accepted on the first edge after `done` falls, i.e. while in IDLE.
- `readAddr` is registered and changes only at edges leaving SAMPLE, or at start acceptance.
- `readdata` is sampled only in SAMPLE; all other values are don't-care.

## Configuration
- Macro: `BBOX_MARGIN_EN`.
- Defined: in FINAL with hit=1:
  - `xMin`=max(minx−MARGIN, 0) and `yMin`=max(miny−MARGIN, 0), with no underflow.
  - `xMax`=min(maxx+MARGIN, WIDTH−1) and `yMax`=min(maxy+MARGIN, HEIGHT−1).
- Undefined: the box is exact. `MARGIN` has no effect.
- The no-hit full-frame result is identical in both builds.

## Test plan
1. **Basic box.** WIDTH=4, HEIGHT=3, BPP=1, READ_LAT=2, THRESHOLD=128. All bytes 255 except (1,1)=0 and (2,2)=10 -> `found`=1, box x 1..2, y 1..2, `done` at E0+37.
2. **Empty image.** Same geometry, all bytes 255 -> `found`=0, `xMin`=0, `xMax`=3, `yMin`=0, `yMax`=2.
3. **Channel rule.** BPP=3. Pixel (3,0) = {0, 0, 200}, not foreground. Pixel (0,2) = {0, 0, 0} -> box x 0..0, y 2..2.
4. **Reset and start handling.** Assert `rst_n`=0 after 5 bytes sampled -> all outputs 0 immediately, no `done`. Restart -> matches test 1. `start` held high for the entire scan -> exactly one `done`.
5. **Margin clamping.** With `BBOX_MARGIN_EN`, 100×100, MARGIN=2, single dark pixel (0,1) -> `xMin`=0, `xMax`=2, `yMin`=0, `yMax`=3.
6. **Address sequence.** `readAddr` steps `BASE_ADDR`, +1, … +N−1, each value held READ_LAT+1 cycles, with no gaps or repeats.
